ctrl_decode_pipe: RTL and testbench

- Parametrised, registered successor to the ID-stage control decoder.
- Decodes mode/opcode/S into execute, memory and write-back controls.
- Evaluates the 4-bit condition field against the NZCV status flags and squashes failed instructions.
- Carries the result through PIPE_DEPTH register stages with global stall and flush, so it drops directly into the ID/EX boundary.

---
 rtl/ctrl_decode_pipe.sv | 191 +++++++++++++++++++
 tb/tb_ctrl_decode_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe
//   Registered ID-stage control decoder. Decodes mode/opcode/S into execute,
//   memory and write-back controls, evaluates the condition field against the
//   NZCV flags (squashing failed instructions), and carries the result through
//   PIPE_DEPTH register stages with global stall and flush.
//
// Parameters
//   CMD_W      width of EXE_CMD (>= 4, upper bits zero)
//   REG_ADDR_W width of destination register tag
//   PIPE_DEPTH register stages between inputs and outputs (1..4)
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   in_valid            instruction fields valid this cycle
//   stall, flush        hold all stages / kill all stages (flush wins)
//   cond, mode, opcode  instruction fields; S = set-flags / load bit
//   status              {N,Z,C,V} flags, sampled with the instruction
//   dest                destination register tag
//   out_valid           output stage holds an instruction
//   WB_EN, MEM_R_EN, MEM_W_EN, B, S_out, EXE_CMD, dest_out  decoded controls
//   cond_fail           instruction squashed by its condition
//   illegal             undefined encoding
module ctrl_decode_pipe #(
    parameter int unsigned CMD_W      = 4,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned PIPE_DEPTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [3:0]            cond,
    input  logic [1:0]            mode,
    input  logic [3:0]            opcode,
    input  logic                  S,
    input  logic [3:0]            status,
    input  logic [REG_ADDR_W-1:0] dest,
    output logic                  out_valid,
    output logic                  WB_EN,
    output logic                  MEM_R_EN,
    output logic                  MEM_W_EN,
    output logic                  B,
    output logic                  S_out,
    output logic [CMD_W-1:0]      EXE_CMD,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic                  cond_fail,
    output logic                  illegal
);

    typedef struct packed {
        logic                  vld;
        logic                  wb;
        logic                  mr;
        logic                  mw;
        logic                  br;
        logic                  sf;
        logic                  cf;
        logic                  ill;
        logic [3:0]            cmd;
        logic [REG_ADDR_W-1:0] dst;
    } stage_t;

    logic [3:0] raw_cmd;
    logic       raw_wb;
    logic       raw_mr;
    logic       raw_mw;
    logic       raw_br;
    logic       raw_sf;
    logic       raw_ill;
    logic       cond_pass;
    stage_t     dec;
    stage_t     pipe [PIPE_DEPTH];

    // Raw decode of mode/opcode/S, before condition and validity are applied
    always_comb begin
        raw_cmd = '0;
        raw_wb  = 1'b0;
        raw_mr  = 1'b0;
        raw_mw  = 1'b0;
        raw_br  = 1'b0;
        raw_sf  = 1'b0;
        raw_ill = 1'b0;
        case (mode)
            2'b00: begin
                raw_sf = S;
                case (opcode)
                    4'b1101: begin raw_cmd = 4'b0001; raw_wb = 1'b1; end // MOV
                    4'b1111: begin raw_cmd = 4'b1001; raw_wb = 1'b1; end // MVN
                    4'b0100: begin raw_cmd = 4'b0010; raw_wb = 1'b1; end // ADD
                    4'b0101: begin raw_cmd = 4'b0011; raw_wb = 1'b1; end // ADC
                    4'b0010: begin raw_cmd = 4'b0100; raw_wb = 1'b1; end // SUB
                    4'b0110: begin raw_cmd = 4'b0101; raw_wb = 1'b1; end // SBC
                    4'b0000: begin raw_cmd = 4'b0110; raw_wb = 1'b1; end // AND
                    4'b1100: begin raw_cmd = 4'b0111; raw_wb = 1'b1; end // ORR
                    4'b0001: begin raw_cmd = 4'b1000; raw_wb = 1'b1; end // EOR
                    4'b1010: begin raw_cmd = 4'b0100; raw_sf = 1'b1; end // CMP
                    4'b1000: begin raw_cmd = 4'b0110; raw_sf = 1'b1; end // TST
                    default: begin raw_ill = 1'b1; raw_sf = 1'b0; end
                endcase
            end
            2'b01: begin
                raw_cmd = 4'b0010;
                if (S) begin
                    raw_wb = 1'b1;
                    raw_mr = 1'b1;
                end else begin
                    raw_mw = 1'b1;
                end
            end
            2'b10: raw_br = 1'b1;
            default: raw_ill = 1'b1;
        endcase
    end

    // Condition evaluation against {N,Z,C,V}
    always_comb begin
        logic n_f, z_f, c_f, v_f;
        {n_f, z_f, c_f, v_f} = status;
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = !z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = !c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = !n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = !v_f;
            4'b1000: cond_pass = c_f && !z_f;
            4'b1001: cond_pass = !c_f || z_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = !z_f && (n_f == v_f);
            4'b1101: cond_pass = z_f || (n_f != v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Stage-0 value: bubble, illegal, squashed, or the decoded controls.
    // Illegal is checked first so it never reports cond_fail.
    always_comb begin
        dec = '0;
        if (in_valid) begin
            dec.vld = 1'b1;
            dec.dst = dest;
            if (raw_ill) begin
                dec.ill = 1'b1;
            end else if (!cond_pass) begin
                dec.cf = 1'b1;
            end else begin
                dec.wb  = raw_wb;
                dec.mr  = raw_mr;
                dec.mw  = raw_mw;
                dec.br  = raw_br;
                dec.sf  = raw_sf;
                dec.cmd = raw_cmd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else if (!stall) begin
            pipe[0] <= dec;
            for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign out_valid = pipe[PIPE_DEPTH-1].vld;
    assign WB_EN     = pipe[PIPE_DEPTH-1].wb;
    assign MEM_R_EN  = pipe[PIPE_DEPTH-1].mr;
    assign MEM_W_EN  = pipe[PIPE_DEPTH-1].mw;
    assign B         = pipe[PIPE_DEPTH-1].br;
    assign S_out     = pipe[PIPE_DEPTH-1].sf;
    assign EXE_CMD   = CMD_W'(pipe[PIPE_DEPTH-1].cmd);
    assign dest_out  = pipe[PIPE_DEPTH-1].dst;
    assign cond_fail = pipe[PIPE_DEPTH-1].cf;
    assign illegal   = pipe[PIPE_DEPTH-1].ill;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Testbench for ctrl_decode_pipe: two instances (depth 1 with default widths,
// depth 3 with CMD_W=6 / REG_ADDR_W=5) driven by the same stimulus, compared
// every cycle against a behavioural model plus directed literal expectations.
module tb_ctrl_decode_pipe;

    typedef struct packed {
        logic       vld;
        logic       wb;
        logic       mr;
        logic       mw;
        logic       br;
        logic       sf;
        logic       cf;
        logic       ill;
        logic [3:0] cmd;
        logic [4:0] dst;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       stall;
    logic       flush;
    logic [3:0] cond;
    logic [1:0] mode;
    logic [3:0] opcode;
    logic       s_bit;
    logic [3:0] status;
    logic [4:0] dest;

    logic       d1_vld, d1_wb, d1_mr, d1_mw, d1_b, d1_s, d1_cf, d1_ill;
    logic [3:0] d1_cmd;
    logic [3:0] d1_dest;
    logic       d3_vld, d3_wb, d3_mr, d3_mw, d3_b, d3_s, d3_cf, d3_ill;
    logic [5:0] d3_cmd;
    logic [4:0] d3_dest;

    int n_chk  = 0;
    int n_fail = 0;

    ctrl_decode_pipe #(.CMD_W(4), .REG_ADDR_W(4), .PIPE_DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .cond(cond), .mode(mode), .opcode(opcode), .S(s_bit), .status(status),
        .dest(dest[3:0]), .out_valid(d1_vld), .WB_EN(d1_wb), .MEM_R_EN(d1_mr),
        .MEM_W_EN(d1_mw), .B(d1_b), .S_out(d1_s), .EXE_CMD(d1_cmd),
        .dest_out(d1_dest), .cond_fail(d1_cf), .illegal(d1_ill)
    );

    ctrl_decode_pipe #(.CMD_W(6), .REG_ADDR_W(5), .PIPE_DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .cond(cond), .mode(mode), .opcode(opcode), .S(s_bit), .status(status),
        .dest(dest), .out_valid(d3_vld), .WB_EN(d3_wb), .MEM_R_EN(d3_mr),
        .MEM_W_EN(d3_mw), .B(d3_b), .S_out(d3_s), .EXE_CMD(d3_cmd),
        .dest_out(d3_dest), .cond_fail(d3_cf), .illegal(d3_ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic exp_t spec_decode(logic iv, logic [3:0] cnd, logic [1:0] md,
                                         logic [3:0] op, logic s, logic [3:0] st,
                                         logic [4:0] dst);
        exp_t e;
        bit   n, z, c, v, ok, legal;
        int   alu;   // -1 marks an undefined data-processing opcode
        bit   wr;
        e = '0;
        if (!iv) return e;
        e.vld = 1'b1;
        e.dst = dst;
        {n, z, c, v} = st;
        case (cnd)
            0: ok = z;            1: ok = !z;
            2: ok = c;            3: ok = !c;
            4: ok = n;            5: ok = !n;
            6: ok = v;            7: ok = !v;
            8: ok = c && !z;      9: ok = !c || z;
            10: ok = (n == v);    11: ok = (n != v);
            12: ok = !z && (n == v);
            13: ok = z || (n != v);
            14: ok = 1;
            default: ok = 0;
        endcase
        alu = -1; wr = 0;
        case (op)
            13: begin alu = 1; wr = 1; end
            15: begin alu = 9; wr = 1; end
            4:  begin alu = 2; wr = 1; end
            5:  begin alu = 3; wr = 1; end
            2:  begin alu = 4; wr = 1; end
            6:  begin alu = 5; wr = 1; end
            0:  begin alu = 6; wr = 1; end
            12: begin alu = 7; wr = 1; end
            1:  begin alu = 8; wr = 1; end
            10: alu = 4;
            8:  alu = 6;
            default: alu = -1;
        endcase
        legal = (md == 1) || (md == 2) || (md == 0 && alu >= 0);
        if (!legal) begin
            e.ill = 1'b1;
        end else if (!ok) begin
            e.cf = 1'b1;
        end else if (md == 0) begin
            e.cmd = 4'(alu);
            e.wb  = wr;
            e.sf  = s || (op == 10) || (op == 8);
        end else if (md == 1) begin
            e.cmd = 4'd2;
            e.wb  = s;
            e.mr  = s;
            e.mw  = !s;
        end else begin
            e.br = 1'b1;
        end
        return e;
    endfunction

    // hist[k] = value accepted k non-stalled edges ago; depth-D output is hist[D-1]
    exp_t hist [4];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) hist[k] = '0;
        end else if (flush) begin
            for (int k = 0; k < 4; k++) hist[k] = '0;
        end else if (!stall) begin
            for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = spec_decode(in_valid, cond, mode, opcode, s_bit, status, dest);
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] vec1(exp_t e);
        return 32'({e.vld, e.wb, e.mr, e.mw, e.br, e.sf, e.cf, e.ill, e.cmd, e.dst[3:0]});
    endfunction

    function automatic logic [31:0] vec3(exp_t e);
        return 32'({e.vld, e.wb, e.mr, e.mw, e.br, e.sf, e.cf, e.ill, 2'b00, e.cmd, e.dst});
    endfunction

    function automatic logic [31:0] act1();
        return 32'({d1_vld, d1_wb, d1_mr, d1_mw, d1_b, d1_s, d1_cf, d1_ill, d1_cmd, d1_dest});
    endfunction

    function automatic logic [31:0] act3();
        return 32'({d3_vld, d3_wb, d3_mr, d3_mw, d3_b, d3_s, d3_cf, d3_ill, d3_cmd, d3_dest});
    endfunction

    function automatic exp_t lit(logic v, logic wb, logic mr, logic mw, logic br,
                                 logic s, logic cf, logic il, logic [3:0] c,
                                 logic [4:0] d);
        exp_t e;
        e = '{vld: v, wb: wb, mr: mr, mw: mw, br: br, sf: s, cf: cf, ill: il,
              cmd: c, dst: d};
        return e;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Inputs change 2 time units after a rising edge; returns 2 units after
    // the edge that captured them.
    task automatic drive(logic iv, logic [3:0] cnd, logic [1:0] md, logic [3:0] op,
                         logic s, logic [3:0] st, logic [4:0] dst,
                         logic stl, logic fl);
        in_valid = iv; cond = cnd; mode = md; opcode = op; s_bit = s;
        status = st; dest = dst; stall = stl; flush = fl;
        @(posedge clk);
        #2;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("model_d1", act1(), vec1(hist[0]));
        check("model_d3", act3(), vec3(hist[2]));
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        in_valid = 0; stall = 0; flush = 0; cond = 0; mode = 0;
        opcode = 0; s_bit = 0; status = 0; dest = 0;
        #1 rst = 1'b0;
        drive(1, 4'he, 2'b00, 4'h4, 1, 4'h0, 5'd3, 0, 0);
        drive(1, 4'he, 2'b00, 4'h4, 1, 4'h0, 5'd3, 0, 0);
        check("reset_d1", act1(), 32'd0);
        check("reset_d3", act3(), 32'd0);
        rst = 1'b1;

        // ADD
        drive(1, 4'he, 2'b00, 4'b0100, 1, 4'h0, 5'd3, 0, 0);
        check("add", act1(), vec1(lit(1,1,0,0,0,1,0,0,4'b0010,5'd3)));
        // LDR then STR
        drive(1, 4'he, 2'b01, 4'h0, 1, 4'h0, 5'd5, 0, 0);
        check("ldr", act1(), vec1(lit(1,1,1,0,0,0,0,0,4'b0010,5'd5)));
        drive(1, 4'he, 2'b01, 4'h0, 0, 4'h0, 5'd6, 0, 0);
        check("str", act1(), vec1(lit(1,0,0,1,0,0,0,0,4'b0010,5'd6)));
        // CMP EQ, condition passes then fails
        drive(1, 4'h0, 2'b00, 4'b1010, 0, 4'b0100, 5'd2, 0, 0);
        check("cmp_pass", act1(), vec1(lit(1,0,0,0,0,1,0,0,4'b0100,5'd2)));
        drive(1, 4'h0, 2'b00, 4'b1010, 0, 4'b0000, 5'd2, 0, 0);
        check("cmp_fail", act1(), vec1(lit(1,0,0,0,0,0,1,0,4'b0000,5'd2)));

        // Depth-3 stall/flush sequence
        drive(0, 4'he, 2'b00, 4'h0, 0, 4'h0, 5'd0, 0, 1);
        drive(1, 4'he, 2'b00, 4'b1101, 0, 4'h0, 5'd17, 0, 0);
        drive(1, 4'he, 2'b00, 4'b0100, 1, 4'h0, 5'd9, 1, 0);
        check("stall1_d3", act3(), 32'd0);
        drive(1, 4'he, 2'b00, 4'b0100, 1, 4'h0, 5'd9, 1, 0);
        check("stall2_d3", act3(), 32'd0);
        drive(0, 4'he, 2'b00, 4'h0, 0, 4'h0, 5'd0, 0, 0);
        check("mov_early_d3", act3(), 32'd0);
        drive(0, 4'he, 2'b00, 4'h0, 0, 4'h0, 5'd0, 0, 0);
        check("mov_d3", act3(), vec3(lit(1,1,0,0,0,0,0,0,4'b0001,5'd17)));
        drive(1, 4'he, 2'b00, 4'b0010, 0, 4'h0, 5'd21, 0, 1);
        check("flush_d3", act3(), 32'd0);
        check("flush_d1", act1(), 32'd0);
        for (int i = 0; i < 3; i++) drive(0, 4'he, 2'b00, 4'h0, 0, 4'h0, 5'd0, 0, 0);
        check("no_sub_d3", act3(), 32'd0);

        // stall+flush together, then an illegal mode with a failing condition
        drive(1, 4'he, 2'b00, 4'b0100, 1, 4'h0, 5'd4, 0, 0);
        drive(1, 4'he, 2'b00, 4'b0100, 1, 4'h0, 5'd4, 1, 1);
        check("stall_flush_d1", act1(), 32'd0);
        drive(1, 4'hf, 2'b11, 4'b0100, 1, 4'h0, 5'd7, 0, 0);
        check("illegal_mode", act1(), vec1(lit(1,0,0,0,0,0,0,1,4'b0000,5'd7)));
        drive(1, 4'he, 2'b00, 4'b1110, 1, 4'h0, 5'd8, 0, 0);
        check("illegal_op", act1(), vec1(lit(1,0,0,0,0,0,0,1,4'b0000,5'd8)));

        // Branch in depth-3 stage 1, then asynchronous reset mid-cycle
        drive(1, 4'he, 2'b10, 4'h0, 0, 4'h0, 5'd12, 0, 0);
        drive(1, 4'he, 2'b00, 4'b1101, 0, 4'h0, 5'd1, 0, 0);
        check("pre_rst_d1", act1(), vec1(lit(1,1,0,0,0,0,0,0,4'b0001,5'd1)));
        #1 rst = 1'b0;
        #1;
        check("async_rst_d1", act1(), 32'd0);
        check("async_rst_d3", act3(), 32'd0);
        #2 rst = 1'b1;
        drive(0, 4'he, 2'b00, 4'h0, 0, 4'h0, 5'd0, 0, 0);
        // Branch literal through depth 3
        drive(1, 4'he, 2'b10, 4'h3, 1, 4'h0, 5'd30, 0, 0);
        drive(0, 4'he, 2'b00, 4'h0, 0, 4'h0, 5'd0, 0, 0);
        drive(0, 4'he, 2'b00, 4'h0, 0, 4'h0, 5'd0, 0, 0);
        check("branch_d3", act3(), vec3(lit(1,0,0,0,1,0,0,0,4'b0000,5'd30)));

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            logic [3:0] rc;
            rc = ($urandom_range(0, 1) == 0) ? 4'he : 4'($urandom_range(0, 15));
            drive($urandom_range(0, 3) != 0, rc, 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                  $urandom_range(0, 6) == 0, $urandom_range(0, 11) == 0);
            if ($urandom_range(0, 79) == 0) begin
                #1 rst = 1'b0;
                #1 rst = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
